regfile_writeback: RTL
======================

# regfile_writeback

Write-port arbiter and buffer in front of the register file's single write port (d_we/d_addr/d_data). It merges two result sources: the in-order ALU writeback, which cannot be back-pressured, and a secondary source such as the load unit or multi-cycle multiply/divide, which uses a valid/ready handshake. Secondary results are queued in a small FIFO and drained in free cycles. Writes to register 0 are suppressed, and a starvation counter issues a one-cycle pipeline stall so the secondary queue always drains.

## Interface
- ADDR_SIZE, 5, register address width
- WORD_SIZE, 32, data width
- FIFO_DEPTH, 4, secondary queue entries; power of two, at least 2
- STARVE_LIMIT, 4, consecutive primary wins with a non-empty queue before a stall is requested; at least 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- a_we  in  1  primary write request (ALU path), no back-pressure
- a_addr  in  ADDR_SIZE  primary destination register
- a_data  in  WORD_SIZE  primary write data
- b_valid  in  1  secondary result valid
- b_ready  out  1  secondary accept; equals !rst && (count != FIFO_DEPTH)
- b_addr  in  ADDR_SIZE  secondary destination register
- b_data  in  WORD_SIZE  secondary write data
- d_we  out  1  register-file write enable, registered
- d_addr  out  ADDR_SIZE  register-file write address, registered
- d_data  out  WORD_SIZE  register-file write data, registered
- stall  out  1  registered; requests upstream to hold a_we=0 for this cycle
- count  out  clog2(FIFO_DEPTH)+1  queue occupancy

## Operation
- Transfer on the secondary port occurs when b_valid && b_ready.
  - If b_addr != 0, push {b_addr, b_data} into the FIFO at the tail.
  - If b_addr == 0, the transfer is accepted and the entry is discarded; count does not change.
- The selection each cycle is registered into d_* at the rising edge, using the first rule that applies:
  1. stall=1 and FIFO non-empty: pop the head and write it.
  2. a_we=1 and a_addr != 0: write {a_addr, a_data}.
  3. FIFO non-empty: pop the head and write it.
  4. Otherwise d_we <= 0, and d_addr/d_data hold their previous values.
- a_we with a_addr == 0 counts as no request.
- The FIFO is never bypassed. An entry pushed at an edge is visible only in the following cycle.
- When a pop and a push occur in the same cycle, count is unchanged. Wrap-around uses pointers modulo FIFO_DEPTH.
- Starvation counter (0..STARVE_LIMIT):
  - Increments on each edge where rule 2 wins while the FIFO is non-empty.
  - Clears on any pop, or when the FIFO is empty.
  - When it reaches STARVE_LIMIT, stall <= 1 for exactly one cycle and the counter clears.
- Stall contract:
  - Upstream must drive a_we=0 in any cycle with stall=1.
  - If a_we=1 anyway, the FIFO still wins and that primary write is lost. This is a protocol violation and the bench flags it.
- No address-conflict handling. The hazard unit guarantees that primary and queued secondary writes never target the same register out of program order.

## Timing
- Reset values: d_we=0, d_addr=0, d_data=0, stall=0, count=0, FIFO pointers 0, starvation counter 0, b_ready=0 while rst=1.
- Reset mid-operation empties the FIFO and drops all queued entries. b_ready returns to 1 in the first cycle after rst deasserts.
- Primary latency: a_we sampled at edge k gives d_we=1 in the cycle after edge k.
- Secondary latency: accepted at edge k gives d_we=1 after edge k+1 at the earliest, if a_we=0 in cycle k+1.
- Full queue: count == FIFO_DEPTH forces b_ready=0, even if a pop happens in the same cycle (no combinational ready-on-pop).
- stall rises after the edge where the counter reaches STARVE_LIMIT and falls after the next edge. The queue head is written out after that next edge.
- Sustained primary writes with a non-empty queue produce one stall every STARVE_LIMIT+1 cycles.

## Test plan
- Reset: hold rst for 3 cycles with b_valid=1 -> all outputs 0 and b_ready=0 during reset; b_ready=1 after release; count=0.
- Primary path:
  - a_we=1, a_addr=3, a_data=0xDEADBEEF -> next cycle d_we=1, d_addr=3, d_data=0xDEADBEEF.
  - a_addr=0 -> d_we=0.
- Queue fill and drain:
  - With a_we=1 (nonzero addresses) held on every cycle while filling, push 4 entries (addresses 5,6,7,8; data 0x10..0x13) on consecutive cycles -> count reaches 4 and b_ready=0.
  - Then drop a_we to 0 -> d_* emits 5,6,7,8 in order on consecutive cycles, and b_ready=1 once count < 4.
- Zero-address discard: a secondary transfer with b_addr=0 and b_data=0xFFFFFFFF -> accepted (b_ready=1), count unchanged, no d_we from it.
- Starvation: queue holds one entry (addr 9), a_we=1 every cycle to addresses 1..4 -> after 4 primary writes stall=1 for one cycle, with the bench driving a_we=0 in that cycle -> next cycle d_addr=9, and stall returns to 0.
- Wrap and simultaneous events: 10 interleaved pushes and pops with push+pop in the same cycle -> count steady, no lost or reordered entries across pointer wrap. Assert rst mid-stream -> queued entries never appear on d_*.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// Bundle of the primary, secondary and register-file write-port signals of regfile_writeback.
// The slave modport is the arbiter's view and the master modport is the surrounding pipeline's view.
interface regfile_writeback_if #(
    parameter int ADDR_SIZE  = 5,
    parameter int WORD_SIZE  = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                 a_we;
    logic [ADDR_SIZE-1:0] a_addr;
    logic [WORD_SIZE-1:0] a_data;

    logic                 b_valid;
    logic                 b_ready;
    logic [ADDR_SIZE-1:0] b_addr;
    logic [WORD_SIZE-1:0] b_data;

    logic                 d_we;
    logic [ADDR_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_data;

    logic                 stall;
    logic [CNT_W-1:0]     count;

    modport slave (
        input  a_we, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output b_ready,
        output d_we, d_addr, d_data,
        output stall, count
    );

    modport master (
        output a_we, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  b_ready,
        input  d_we, d_addr, d_data,
        input  stall, count
    );
endinterface

// File: rtl/regfile_writeback.sv
// Arbitrates the register file's single write port between the un-stallable ALU writeback and a
// queued secondary source; a starvation counter forces a one-cycle stall so the queue always drains.
module regfile_writeback #(
    parameter int ADDR_SIZE    = 5,
    parameter int WORD_SIZE    = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    regfile_writeback_if.slave  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
    } entry_t;

    // NOTE: the queue storage has no reset; only pointers and count define which entries are live.
    entry_t mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q,  count_d;
    logic [STV_W-1:0]     starve_q, starve_d;
    logic                 stall_q,  stall_d;
    logic                 d_we_q,   d_we_d;
    logic [ADDR_SIZE-1:0] d_addr_q, d_addr_d;
    logic [WORD_SIZE-1:0] d_data_q, d_data_d;

    logic   b_ready;
    logic   push;
    logic   pop;
    logic   non_empty;
    logic   a_req;
    entry_t head;

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign b_ready   = !rst && (count_q != CNT_W'(FIFO_DEPTH));
    assign push      = bus.b_valid && b_ready && (bus.b_addr != '0);
    assign non_empty = (count_q != '0);
    assign a_req     = bus.a_we && (bus.a_addr != '0);
    assign pop       = non_empty && (stall_q || !a_req);
    assign head      = mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Write-port selection; an idle cycle keeps the previous address and data.
    always_comb begin
        d_we_d   = 1'b0;
        d_addr_d = d_addr_q;
        d_data_d = d_data_q;
        if (pop) begin
            d_we_d   = 1'b1;
            d_addr_d = head.addr;
            d_data_d = head.data;
        end else if (a_req) begin
            d_we_d   = 1'b1;
            d_addr_d = bus.a_addr;
            d_data_d = bus.a_data;
        end
    end

    // Without a pop and with a non-empty queue, the primary path is the winner this cycle.
    always_comb begin
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (pop || !non_empty) begin
            starve_d = '0;
        end else if (starve_q == STV_W'(STARVE_LIMIT - 1)) begin
            starve_d = '0;
            stall_d  = 1'b1;
        end else begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            d_we_q   <= 1'b0;
            d_addr_q <= '0;
            d_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            d_we_q   <= d_we_d;
            d_addr_q <= d_addr_d;
            d_data_q <= d_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{addr: bus.b_addr, data: bus.b_data};
    end

    assign bus.b_ready = b_ready;
    assign bus.d_we    = d_we_q;
    assign bus.d_addr  = d_addr_q;
    assign bus.d_data  = d_data_q;
    assign bus.stall   = stall_q;
    assign bus.count   = count_q;
endmodule
